// File: rtl/knap_search_ctrl.sv
// ---------------------------------------------------------------------------
// knap_search_ctrl
//   Exhaustive-search oracle for the multi-constraint knapsack checker.
//   Holds a loadable item table (value/weight/volume) and enumerates every
//   selection mask, one per clock. Each mask is checked against the latched
//   min-value / max-weight / max-volume limits. The block reports the best
//   valid selection and how many selections were valid.
//
// Ports
//   i_clk, i_rst        clock (rising edge), asynchronous active-high reset
//   i_cfg_we/addr       item table write strobe and index (IDLE/DONE only)
//   i_cfg_value/weight/volume   item data written at i_cfg_addr
//   i_min_value, i_max_weight, i_max_volume   limits, latched on start
//   i_start             one-cycle pulse, accepted only in IDLE
//   o_busy              high through SCAN and DRAIN
//   o_done              one-cycle pulse; results valid from this cycle
//   o_found             at least one valid mask was seen
//   o_best_mask/value/weight/volume   best valid selection and its totals
//   o_valid_count       number of valid masks
// ---------------------------------------------------------------------------
module knap_search_ctrl #(
    parameter  int N_ITEMS = 5,
    parameter  int W       = 32,
    localparam int AW      = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_cfg_we,
    input  logic [AW-1:0]      i_cfg_addr,
    input  logic [W-1:0]       i_cfg_value,
    input  logic [W-1:0]       i_cfg_weight,
    input  logic [W-1:0]       i_cfg_volume,
    input  logic [W-1:0]       i_min_value,
    input  logic [W-1:0]       i_max_weight,
    input  logic [W-1:0]       i_max_volume,
    input  logic               i_start,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_found,
    output logic [N_ITEMS-1:0] o_best_mask,
    output logic [W-1:0]       o_best_value,
    output logic [W-1:0]       o_best_weight,
    output logic [W-1:0]       o_best_volume,
    output logic [N_ITEMS:0]   o_valid_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             r_state;

    // item table
    logic [W-1:0]       r_val [N_ITEMS];
    logic [W-1:0]       r_wgt [N_ITEMS];
    logic [W-1:0]       r_vol [N_ITEMS];

    // limits latched at start
    logic [W-1:0]       r_min_value;
    logic [W-1:0]       r_max_weight;
    logic [W-1:0]       r_max_volume;

    // mask generator and evaluation stage 1
    logic [N_ITEMS-1:0] r_mask;
    logic [N_ITEMS-1:0] r_s1_mask;
    logic               r_s1_vld;

    // registered outputs
    logic               r_busy;
    logic               r_done;
    logic               r_found;
    logic [N_ITEMS-1:0] r_best_mask;
    logic [W-1:0]       r_best_value;
    logic [W-1:0]       r_best_weight;
    logic [W-1:0]       r_best_volume;
    logic [N_ITEMS:0]   r_valid_count;

    // stage 2 combinational results
    logic [W-1:0]       w_sum_val;
    logic [W-1:0]       w_sum_wgt;
    logic [W-1:0]       w_sum_vol;
    logic               w_ok;
    logic               w_better;
    logic               w_cfg_open;

    // Table may only change while no search is in flight.
    assign w_cfg_open = (r_state == ST_IDLE) || (r_state == ST_DONE);

    // Item table write port; an address beyond the table matches no entry.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < N_ITEMS; i++) begin
                r_val[i] <= '0;
                r_wgt[i] <= '0;
                r_vol[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_ITEMS; i++) begin
                if (i_cfg_we && w_cfg_open && (i_cfg_addr == AW'(i))) begin
                    r_val[i] <= i_cfg_value;
                    r_wgt[i] <= i_cfg_weight;
                    r_vol[i] <= i_cfg_volume;
                end
            end
        end
    end

    // Stage 2: modulo-2^W totals of the stage-1 mask, constraint test and
    // best-candidate comparison (lower mask keeps full ties since it came first).
    always_comb begin
        w_sum_val = '0;
        w_sum_wgt = '0;
        w_sum_vol = '0;
        for (int i = 0; i < N_ITEMS; i++) begin
            if (r_s1_mask[i]) begin
                w_sum_val = w_sum_val + r_val[i];
                w_sum_wgt = w_sum_wgt + r_wgt[i];
                w_sum_vol = w_sum_vol + r_vol[i];
            end else begin
                w_sum_val = w_sum_val;
                w_sum_wgt = w_sum_wgt;
                w_sum_vol = w_sum_vol;
            end
        end
        w_ok     = (w_sum_val >= r_min_value) &&
                   (w_sum_wgt <= r_max_weight) &&
                   (w_sum_vol <= r_max_volume);
        w_better = !r_found ||
                   (w_sum_val > r_best_value) ||
                   ((w_sum_val == r_best_value) && (w_sum_wgt < r_best_weight));
    end

    // Control FSM, mask generator, stage-1 register and result commit.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_min_value   <= '0;
            r_max_weight  <= '0;
            r_max_volume  <= '0;
            r_mask        <= '0;
            r_s1_mask     <= '0;
            r_s1_vld      <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_found       <= 1'b0;
            r_best_mask   <= '0;
            r_best_value  <= '0;
            r_best_weight <= '0;
            r_best_volume <= '0;
            r_valid_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_state       <= ST_SCAN;
                        r_busy        <= 1'b1;
                        r_min_value   <= i_min_value;
                        r_max_weight  <= i_max_weight;
                        r_max_volume  <= i_max_volume;
                        r_mask        <= '0;
                        r_s1_vld      <= 1'b0;
                        r_found       <= 1'b0;
                        r_best_mask   <= '0;
                        r_best_value  <= '0;
                        r_best_weight <= '0;
                        r_best_volume <= '0;
                        r_valid_count <= '0;
                    end
                end
                ST_SCAN: begin
                    r_s1_mask <= r_mask;
                    r_s1_vld  <= 1'b1;
                    r_mask    <= r_mask + N_ITEMS'(1);
                    if (r_mask == {N_ITEMS{1'b1}}) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // the last mask commits on this edge
                    r_s1_vld <= 1'b0;
                    r_state  <= ST_DONE;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b1;
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b0;
                    r_s1_vld <= 1'b0;
                end
            endcase

            // r_s1_vld is never set in IDLE, so this cannot collide with the
            // result clear on start.
            if (r_s1_vld && w_ok) begin
                r_found       <= 1'b1;
                r_valid_count <= r_valid_count + (N_ITEMS + 1)'(1);
                if (w_better) begin
                    r_best_mask   <= r_s1_mask;
                    r_best_value  <= w_sum_val;
                    r_best_weight <= w_sum_wgt;
                    r_best_volume <= w_sum_vol;
                end
            end
        end
    end

    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_found       = r_found;
    assign o_best_mask   = r_best_mask;
    assign o_best_value  = r_best_value;
    assign o_best_weight = r_best_weight;
    assign o_best_volume = r_best_volume;
    assign o_valid_count = r_valid_count;

endmodule

// File: tb/tb_knap_search_ctrl.sv
// ---------------------------------------------------------------------------
// tb_knap_search_ctrl
//   Self-checking bench for knap_search_ctrl. A reference model evaluates all
//   selections directly from the item table and limits; scenario tasks compare
//   latency, busy/done shape and results.
// ---------------------------------------------------------------------------
module tb_knap_search_ctrl;

    localparam int N  = 5;
    localparam int W  = 32;
    localparam int RW = 1 + N + 3 * W + (N + 1);
    // done rises on the 33rd edge after the start edge (high in cycle k+34)
    localparam int DONE_LAT = 33;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_we;
    logic [2:0]    cfg_addr;
    logic [W-1:0]  cfg_value, cfg_weight, cfg_volume;
    logic [W-1:0]  min_value, max_weight, max_volume;
    logic          start;
    logic          busy, done, found;
    logic [N-1:0]  best_mask;
    logic [W-1:0]  best_value, best_weight, best_volume;
    logic [N:0]    valid_count;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] m_val [N];
    logic [W-1:0] m_wgt [N];
    logic [W-1:0] m_vol [N];

    knap_search_ctrl #(.N_ITEMS(N), .W(W)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_cfg_we      (cfg_we),
        .i_cfg_addr    (cfg_addr),
        .i_cfg_value   (cfg_value),
        .i_cfg_weight  (cfg_weight),
        .i_cfg_volume  (cfg_volume),
        .i_min_value   (min_value),
        .i_max_weight  (max_weight),
        .i_max_volume  (max_volume),
        .i_start       (start),
        .o_busy        (busy),
        .o_done        (done),
        .o_found       (found),
        .o_best_mask   (best_mask),
        .o_best_value  (best_value),
        .o_best_weight (best_weight),
        .o_best_volume (best_volume),
        .o_valid_count (valid_count)
    );

    always #5 clk = ~clk;

    function automatic logic [RW-1:0] got();
        return {found, best_mask, best_value, best_weight, best_volume, valid_count};
    endfunction

    // Reference: try every selection, keep the best by the ranking rules.
    function automatic logic [RW-1:0] model(input logic [W-1:0] mn,
                                            input logic [W-1:0] mw,
                                            input logic [W-1:0] mv);
        logic         f;
        logic [N-1:0] bm;
        logic [W-1:0] bv, bw, bo, tv, tw, to;
        int           cnt;
        f = 1'b0; bm = '0; bv = '0; bw = '0; bo = '0; cnt = 0;
        for (int m = 0; m < (1 << N); m++) begin
            tv = '0; tw = '0; to = '0;
            for (int i = 0; i < N; i++) begin
                if (m[i]) begin
                    tv = tv + m_val[i];
                    tw = tw + m_wgt[i];
                    to = to + m_vol[i];
                end
            end
            if (tv >= mn && tw <= mw && to <= mv) begin
                if (!f || tv > bv || (tv == bv && tw < bw)) begin
                    bm = m[N-1:0]; bv = tv; bw = tw; bo = to;
                end
                f = 1'b1;
                cnt++;
            end
        end
        return {f, bm, bv, bw, bo, cnt[N:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_item(input int a, input logic [W-1:0] v,
                             input logic [W-1:0] w, input logic [W-1:0] o);
        cfg_we = 1'b1; cfg_addr = a[2:0];
        cfg_value = v; cfg_weight = w; cfg_volume = o;
        step();
        cfg_we = 1'b0;
        if (a < N) begin
            m_val[a] = v; m_wgt[a] = w; m_vol[a] = o;
        end
    endtask

    task automatic load_plan_table();
        load_item(0, 32'd4,  32'd12, 32'd1);
        load_item(1, 32'd2,  32'd1,  32'd1);
        load_item(2, 32'd2,  32'd2,  32'd1);
        load_item(3, 32'd1,  32'd1,  32'd1);
        load_item(4, 32'd10, 32'd4,  32'd1);
    endtask

    // Pulse start and follow the search; lat = edges from start edge to done,
    // shape counts busy/done deviations. inj_at > 0 pulses start and a table
    // write in the middle of the scan.
    task automatic run_search(input int inj_at, output int lat, output int shape);
        lat = -1; shape = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        if (busy !== 1'b1) shape++;
        for (int n = 1; n <= 60; n++) begin
            if (n == inj_at) begin
                start = 1'b1; cfg_we = 1'b1; cfg_addr = 3'd0;
                cfg_value = 32'd1000; cfg_weight = 32'd0; cfg_volume = 32'd0;
            end
            step();
            start = 1'b0; cfg_we = 1'b0;
            if (busy !== (n < DONE_LAT)) shape++;
            if (lat < 0 && done === 1'b1) begin
                lat = n;
            end else if (lat >= 0) begin
                if (done !== 1'b0) shape++;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        total++;
        if ({busy, done, got()} !== '0) begin
            bad++;
            $display("FAIL reset_state got=%h exp=0", {busy, done, got()});
        end
        for (int i = 0; i < N; i++) begin
            m_val[i] = '0; m_wgt[i] = '0; m_vol[i] = '0;
        end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_plan_basic();
        int lat, shape;
        load_plan_table();
        min_value = 32'd15; max_weight = 32'd16; max_volume = 32'd10;
        run_search(0, lat, shape);
        total++;
        if (lat !== DONE_LAT || shape !== 0) begin
            bad++;
            $display("FAIL basic_timing lat=%0d shape_err=%0d exp lat=%0d shape_err=0", lat, shape, DONE_LAT);
        end
        total++;
        if (got() !== {1'b1, 5'b11110, 32'd15, 32'd8, 32'd4, 6'd1}) begin
            bad++;
            $display("FAIL basic_result got=%h", got());
        end
    endtask

    task automatic test_min_zero();
        int lat, shape;
        min_value = 32'd0; max_weight = 32'd16; max_volume = 32'd10;
        run_search(0, lat, shape);
        total++;
        if (lat !== DONE_LAT || shape !== 0) begin
            bad++;
            $display("FAIL minzero_timing lat=%0d shape_err=%0d", lat, shape);
        end
        total++;
        if (got() !== {1'b1, 5'b11110, 32'd15, 32'd8, 32'd4, 6'd25}) begin
            bad++;
            $display("FAIL minzero_result got=%h", got());
        end
    endtask

    task automatic test_no_valid();
        int lat, shape;
        min_value = 32'd15; max_weight = 32'd16; max_volume = 32'd0;
        run_search(0, lat, shape);
        total++;
        if (lat !== DONE_LAT || shape !== 0) begin
            bad++;
            $display("FAIL novalid_timing lat=%0d shape_err=%0d", lat, shape);
        end
        total++;
        if (got() !== '0) begin
            bad++;
            $display("FAIL novalid_result got=%h exp=0", got());
        end
    endtask

    task automatic test_tiebreak();
        int lat, shape;
        load_item(0, 32'd3, 32'd5, 32'd0);
        load_item(1, 32'd3, 32'd2, 32'd0);
        for (int i = 2; i < N; i++) load_item(i, 32'd0, 32'd0, 32'd0);
        min_value = 32'd3; max_weight = 32'hFFFF_FFFF; max_volume = 32'hFFFF_FFFF;
        run_search(0, lat, shape);
        total++;
        if (lat !== DONE_LAT || shape !== 0) begin
            bad++;
            $display("FAIL tie_timing lat=%0d shape_err=%0d", lat, shape);
        end
        total++;
        if (got() !== {1'b1, 5'b00011, 32'd6, 32'd7, 32'd0, 6'd24}) begin
            bad++;
            $display("FAIL tie_pair got=%h", got());
        end
        load_item(1, 32'd0, 32'd2, 32'd0);
        load_item(0, 32'd3, 32'd2, 32'd0);
        run_search(0, lat, shape);
        total++;
        if (lat !== DONE_LAT || shape !== 0) begin
            bad++;
            $display("FAIL tie2_timing lat=%0d shape_err=%0d", lat, shape);
        end
        total++;
        if (got() !== {1'b1, 5'b00001, 32'd3, 32'd2, 32'd0, 6'd16}) begin
            bad++;
            $display("FAIL tie_earlier got=%h", got());
        end
    endtask

    task automatic test_mid_reset();
        int lat, shape, dones;
        load_plan_table();
        min_value = 32'd0; max_weight = 32'd16; max_volume = 32'd10;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (12) step();
        rst = 1'b1;
        #1;
        total++;
        if ({busy, done, got()} !== '0) begin
            bad++;
            $display("FAIL midreset_clear got=%h exp=0", {busy, done, got()});
        end
        #1;
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            m_val[i] = '0; m_wgt[i] = '0; m_vol[i] = '0;
        end
        dones = 0;
        for (int n = 0; n < 40; n++) begin
            step();
            if (done === 1'b1) dones++;
        end
        total++;
        if (dones !== 0) begin
            bad++;
            $display("FAIL midreset_nodone got=%0d exp=0", dones);
        end
        // table was cleared by reset: every selection totals zero
        run_search(0, lat, shape);
        total++;
        if (lat !== DONE_LAT || shape !== 0) begin
            bad++;
            $display("FAIL cleared_timing lat=%0d shape_err=%0d", lat, shape);
        end
        total++;
        if (got() !== model(min_value, max_weight, max_volume)) begin
            bad++;
            $display("FAIL cleared_table got=%h exp=%h", got(), model(min_value, max_weight, max_volume));
        end
        load_plan_table();
        run_search(0, lat, shape);
        total++;
        if (lat !== DONE_LAT || shape !== 0) begin
            bad++;
            $display("FAIL rerun_timing lat=%0d shape_err=%0d", lat, shape);
        end
        total++;
        if (got() !== model(min_value, max_weight, max_volume)) begin
            bad++;
            $display("FAIL rerun_result got=%h exp=%h", got(), model(min_value, max_weight, max_volume));
        end
    endtask

    task automatic test_busy_ignore();
        int lat, shape;
        load_plan_table();
        min_value = 32'd15; max_weight = 32'd16; max_volume = 32'd10;
        run_search(5, lat, shape);
        total++;
        if (lat !== DONE_LAT || shape !== 0) begin
            bad++;
            $display("FAIL busy_timing lat=%0d shape_err=%0d", lat, shape);
        end
        // same search again: a write accepted while busy would now show up
        run_search(0, lat, shape);
        total++;
        if (got() !== model(min_value, max_weight, max_volume) || lat !== DONE_LAT) begin
            bad++;
            $display("FAIL busy_table got=%h exp=%h lat=%0d", got(), model(min_value, max_weight, max_volume), lat);
        end
    endtask

    task automatic test_random();
        int lat, shape;
        logic [RW-1:0] exp_r;
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < N; i++) begin
                if (it < 5)
                    load_item(i, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
                else
                    load_item(i, $urandom(), $urandom(), $urandom());
            end
            // out-of-range address must be dropped
            load_item($urandom_range(N, 7), $urandom(), $urandom(), $urandom());
            if (it < 5) begin
                min_value  = $urandom_range(0, 40);
                max_weight = $urandom_range(0, 50);
                max_volume = $urandom_range(0, 50);
            end else begin
                min_value  = $urandom();
                max_weight = $urandom();
                max_volume = $urandom();
            end
            run_search(0, lat, shape);
            total++;
            if (lat !== DONE_LAT || shape !== 0) begin
                bad++;
                $display("FAIL rand_timing it=%0d lat=%0d shape_err=%0d", it, lat, shape);
            end
            exp_r = model(min_value, max_weight, max_volume);
            total++;
            if (got() !== exp_r) begin
                bad++;
                $display("FAIL rand_result it=%0d got=%h exp=%h", it, got(), exp_r);
            end
        end
    endtask

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0;
        cfg_value = '0; cfg_weight = '0; cfg_volume = '0;
        min_value = '0; max_weight = '0; max_volume = '0;
        start = 1'b0;
        test_reset();
        test_plan_basic();
        test_min_zero();
        test_no_valid();
        test_tiebreak();
        test_mid_reset();
        test_busy_ignore();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/knap_search_ctrl.md
Name: knap_search_ctrl

Overview:
- Sequential exhaustive-search controller for the multi-constraint knapsack checker datapath.
- Holds a loadable item table (value/weight/volume per item) and enumerates all 2^N_ITEMS selection masks, one per clock.
- Evaluates each mask against the min-value, max-weight and max-volume limits.
- Reports the best valid selection plus the count of valid selections. Serves as the classical reference/oracle engine beside the generated constraint checkers.

Parameters:
- N_ITEMS, 5: number of items; mask bit i selects item i (bit0 = A ... bit4 = E).
- W, 32: width of values, weights, volumes, limits and all totals.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- cfg_we  input  1  item table write strobe.
- cfg_addr  input  $clog2(N_ITEMS)  item index to write.
- cfg_value  input  W  item value.
- cfg_weight  input  W  item weight.
- cfg_volume  input  W  item volume.
- min_value  input  W  constraint; sampled at start.
- max_weight  input  W  constraint; sampled at start.
- max_volume  input  W  constraint; sampled at start.
- start  input  1  begin search (one-cycle pulse).
- busy  output  1  search in progress.
- done  output  1  one-cycle pulse; results valid from this cycle.
- found  output  1  at least one valid mask seen.
- best_mask  output  N_ITEMS  best valid selection.
- best_value  output  W  total value of best_mask.
- best_weight  output  W  total weight of best_mask.
- best_volume  output  W  total volume of best_mask.
- valid_count  output  N_ITEMS+1  number of valid masks.

Behaviour:
- Reset (async, any state):
  - FSM goes to IDLE; item table cleared to 0; latched limits cleared.
  - busy, done, found, best_*, valid_count all go to 0.
  - A reset mid-search abandons the search; no done is produced.
- Item table:
  - cfg_we writes entry cfg_addr on the rising edge, only in IDLE or DONE.
  - Writes are ignored while busy. cfg_addr >= N_ITEMS is ignored.
- FSM states: IDLE, SCAN, DRAIN, DONE.
  - IDLE -> SCAN on start = 1.
    - Latch the limits.
    - Clear found, best_*, valid_count, and set mask to 0.
  - SCAN: each cycle, mask is presented to the evaluation stage and incremented. After the all-ones mask is issued, go to DRAIN.
  - DRAIN: one cycle; the last evaluation is committed.
  - DONE: done = 1 for exactly one cycle, then back to IDLE.
  - start is ignored outside IDLE.
- Timing: with start sampled at edge k, SCAN occupies cycles k+1 .. k+2^N_ITEMS, DRAIN is cycle k+2^N_ITEMS+1, and done is high in cycle k+2^N_ITEMS+2.
  - busy is high from SCAN through DRAIN and low in DONE and IDLE.
- Evaluation pipeline:
  - Stage 1 registers the mask.
  - Stage 2 sums the selected entries combinationally and registers the commit.
  - Sums are W-bit, modulo 2^W (unsigned wrap, no saturation).
  - valid = total_value >= min_value AND total_weight <= max_weight AND total_volume <= max_volume, all unsigned.
- Best update on a valid mask:
  - Replace if found = 0, or value > best_value, or (value == best_value AND weight < best_weight).
  - Otherwise keep the incumbent; the earlier (lower) mask wins full ties.
  - On each valid mask, valid_count increments and found is set.
- Outputs hold their values after done until the next start or reset.
- Empty mask (0) is evaluated like any other mask; it is valid if min_value = 0.
- Results are undefined only if the table is modified during the search, which is prevented by the write rule above.

Test Plan:
- Load values 4,2,2,1,10, weights 12,1,2,1,4 and volumes 1,1,1,1,1, with min 15, max_weight 16, max_volume 10; pulse start -> done exactly 34 cycles after the start edge, found = 1, best_mask = 5'b11110, best_value = 15, best_weight = 8, best_volume = 4, valid_count = 1.
- Same table with min_value = 0 -> found = 1, best_mask = 5'b11110, best_value = 15, valid_count = 25.
- Same table with max_volume = 0 and min_value = 15 -> found = 0, best_* = 0, valid_count = 0, done still pulses once.
- Tie-break: values 3,3,0,0,0, weights 5,2,0,0,0, min 3, limits large -> best_mask = 5'b00011 (value 6); then set the item 1 value to 0 and item 0 weight to 2 -> best_mask = 5'b00001, the earlier mask kept on a full tie.
- Assert rst midway through SCAN -> busy/done/found/valid_count drop to 0 immediately (asynchronously); no done follows; a subsequent start runs a full search normally.
- Pulse start while busy and cfg_we while busy -> both ignored: done timing unchanged and the table unchanged on readback via results.
